// File: rtl/mem_arbiter.sv
// Arbitrates the byte-serial memory engine between instruction fetch and the LSB.
// Optional ARB_PERF_CNT_EN adds grant and IO-stall performance counters.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter logic [31:0] IO_BASE    = 32'h0003_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear_up,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    output logic        eng_valid,
    input  logic        eng_ready,
    output logic        eng_wr,
    output logic [31:0] eng_addr,
    output logic [1:0]  eng_size,
    output logic [31:0] eng_wdata,
    input  logic        eng_done,
    input  logic [31:0] eng_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_lsb_grants,
    output logic [31:0] perf_io_stall_cycles
`endif
);

    localparam int unsigned   SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LSB
    } owner_e;

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          wr_q, wr_d;
    logic [31:0]   addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          discard_q, discard_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   if_data_q, if_data_d;
    logic [31:0]   lsb_rdata_q, lsb_rdata_d;

    logic lsb_io_blk;
    logic lsb_elig;
    logic starve_force;
    logic grant_lsb;
    logic grant_if;
    logic gnt_lsb_fire;
    logic gnt_if_fire;
    logic flush_kill;
    logic complete;

    assign lsb_io_blk   = lsb_req && (lsb_addr >= IO_BASE) && io_buffer_full;
    assign lsb_elig     = lsb_req && !lsb_io_blk;
    assign starve_force = (starve_q == STARVE_LIM) && if_req;
    assign grant_lsb    = lsb_elig && !starve_force;
    assign grant_if     = if_req && !grant_lsb;
    assign gnt_lsb_fire = rdy_in && (state_q == ST_IDLE) && !rob_clear_up && grant_lsb;
    assign gnt_if_fire  = rdy_in && (state_q == ST_IDLE) && !rob_clear_up && grant_if;

    // Committed stores are never discarded by a flush.
    assign flush_kill   = rob_clear_up && !((owner_q == OWN_LSB) && wr_q);
    assign complete     = rdy_in && eng_done &&
                          (((state_q == ST_ISSUE) && eng_ready) || (state_q == ST_WAIT));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        discard_d   = discard_q;
        starve_d    = starve_q;
        if_data_d   = if_data_q;
        lsb_rdata_d = lsb_rdata_q;

        if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (!if_req) begin
                        starve_d = '0;
                    end
                    if (gnt_lsb_fire) begin
                        owner_d = OWN_LSB;
                        wr_d    = lsb_wr;
                        addr_d  = lsb_addr;
                        size_d  = lsb_size;
                        wdata_d = lsb_wdata;
                        state_d = ST_ISSUE;
                        if (if_req && (starve_q != STARVE_LIM)) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else if (gnt_if_fire) begin
                        owner_d = OWN_IF;
                        wr_d    = 1'b0;
                        addr_d  = if_addr;
                        size_d  = 2'd2;
                        wdata_d = '0;
                        state_d = ST_ISSUE;
                        // A fetch that only won because the LSB is IO-blocked keeps the count.
                        if (!lsb_io_blk) begin
                            starve_d = '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (flush_kill) begin
                        discard_d = 1'b1;
                    end
                    if (eng_ready) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush_kill) begin
                        discard_d = 1'b1;
                    end
                end
                ST_RESP: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (complete) begin
                discard_d = 1'b0;
                if (discard_q || flush_kill) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_IF) begin
                        if_data_d = eng_rdata;
                    end else begin
                        lsb_rdata_d = eng_rdata;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            discard_q   <= 1'b0;
            starve_q    <= '0;
            if_data_q   <= '0;
            lsb_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            discard_q   <= discard_d;
            starve_q    <= starve_d;
            if_data_q   <= if_data_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    assign eng_valid = (state_q == ST_ISSUE);
    assign eng_wr    = wr_q;
    assign eng_addr  = addr_q;
    assign eng_size  = size_q;
    assign eng_wdata = wdata_q;

    // RESP holds through a freeze, so the done appears once rdy_in returns.
    assign if_done   = rdy_in && (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign lsb_done  = rdy_in && (state_q == ST_RESP) && (owner_q == OWN_LSB);
    assign if_data   = if_data_q;
    assign lsb_rdata = lsb_rdata_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_lsb_q, perf_lsb_d;
    logic [31:0] perf_io_q, perf_io_d;

    always_comb begin
        perf_if_d  = perf_if_q;
        perf_lsb_d = perf_lsb_q;
        perf_io_d  = perf_io_q;
        if (gnt_if_fire) begin
            perf_if_d = perf_if_q + 32'd1;
        end
        if (gnt_lsb_fire) begin
            perf_lsb_d = perf_lsb_q + 32'd1;
        end
        if (rdy_in && lsb_io_blk) begin
            perf_io_d = perf_io_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_if_q  <= '0;
            perf_lsb_q <= '0;
            perf_io_q  <= '0;
        end else begin
            perf_if_q  <= perf_if_d;
            perf_lsb_q <= perf_lsb_d;
            perf_io_q  <= perf_io_d;
        end
    end

    assign perf_if_grants       = perf_if_q;
    assign perf_lsb_grants      = perf_lsb_q;
    assign perf_io_stall_cycles = perf_io_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the bench plays the memory engine.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear_up;
    logic        io_buffer_full;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req;
    logic        lsb_wr;
    logic [31:0] lsb_addr;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic        eng_valid;
    logic        eng_ready;
    logic        eng_wr;
    logic [31:0] eng_addr;
    logic [1:0]  eng_size;
    logic [31:0] eng_wdata;
    logic        eng_done;
    logic [31:0] eng_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_grants;
    logic [31:0] perf_lsb_grants;
    logic [31:0] perf_io_stall_cycles;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] seen_addr;
    logic [31:0] last_if;
    logic [31:0] last_lsb;

    always #5 clk_in = ~clk_in;

    mem_arbiter #(.STARVE_MAX(4), .IO_BASE(32'h0003_0000)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .rob_clear_up   (rob_clear_up),
        .io_buffer_full (io_buffer_full),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .lsb_req        (lsb_req),
        .lsb_wr         (lsb_wr),
        .lsb_addr       (lsb_addr),
        .lsb_size       (lsb_size),
        .lsb_wdata      (lsb_wdata),
        .lsb_done       (lsb_done),
        .lsb_rdata      (lsb_rdata),
        .eng_valid      (eng_valid),
        .eng_ready      (eng_ready),
        .eng_wr         (eng_wr),
        .eng_addr       (eng_addr),
        .eng_size       (eng_size),
        .eng_wdata      (eng_wdata),
        .eng_done       (eng_done),
        .eng_rdata      (eng_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_grants       (perf_if_grants),
        .perf_lsb_grants      (perf_lsb_grants),
        .perf_io_stall_cycles (perf_io_stall_cycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_valid();
        bit found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (eng_valid) begin
                found = 1'b1;
                break;
            end
            step();
        end
        if (!found) begin
            check("valid_timeout", 32'd0, 32'd1);
        end
    endtask

    // Accept the pending transaction, then return done after 'delay' cycles.
    // Returns in the cycle where the owner's done is expected.
    task automatic serve(input logic [31:0] rdata, input int unsigned delay,
                         output logic [31:0] addr_seen);
        wait_valid();
        addr_seen = eng_addr;
        eng_ready = 1'b1;
        step();
        eng_ready = 1'b0;
        repeat (delay) step();
        eng_done  = 1'b1;
        eng_rdata = rdata;
        step();
        eng_done  = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        rob_clear_up = 1'b0;
        io_buffer_full = 1'b0;
        if_req = 1'b0;
        if_addr = '0;
        lsb_req = 1'b0;
        lsb_wr = 1'b0;
        lsb_addr = '0;
        lsb_size = '0;
        lsb_wdata = '0;
        eng_ready = 1'b0;
        eng_done = 1'b0;
        eng_rdata = '0;

        // Reset state
        #1;
        check("rst_valid", {31'd0, eng_valid}, 32'd0);
        check("rst_if_done", {31'd0, if_done}, 32'd0);
        check("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
        check("rst_addr", eng_addr, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        step();
        step();
        rst_in = 1'b0;
        step();

        // 1: fetch only, one cycle grant latency
        if_req = 1'b1;
        if_addr = 32'h100;
        eng_ready = 1'b1;
        #1;
        check("t1_valid_c0", {31'd0, eng_valid}, 32'd0);
        step();
        check("t1_valid_c1", {31'd0, eng_valid}, 32'd1);
        check("t1_size", {30'd0, eng_size}, 32'd2);
        check("t1_wr", {31'd0, eng_wr}, 32'd0);
        check("t1_addr", eng_addr, 32'h100);
        step();
        eng_ready = 1'b0;
        check("t1_valid_drop", {31'd0, eng_valid}, 32'd0);
        repeat (3) step();
        check("t1_no_early_done", {31'd0, if_done}, 32'd0);
        eng_done = 1'b1;
        eng_rdata = 32'h00A0_0093;
        step();
        eng_done = 1'b0;
        check("t1_if_done", {31'd0, if_done}, 32'd1);
        check("t1_if_data", if_data, 32'h00A0_0093);
        last_if = 32'h00A0_0093;
        if_req = 1'b0;
        step();
        check("t1_done_once", {31'd0, if_done}, 32'd0);

        // 2: contention, fetch forced after four LSB grants
        if_req = 1'b1;
        if_addr = 32'h200;
        lsb_req = 1'b1;
        lsb_wr = 1'b0;
        lsb_addr = 32'h2000;
        lsb_size = 2'd2;
        for (int i = 0; i < 6; i++) begin
            serve(32'h1000 + 32'(i), 1, seen_addr);
            if (i == 4) begin
                check("t2_fetch_addr", seen_addr, 32'h200);
                check("t2_if_done", {31'd0, if_done}, 32'd1);
                check("t2_if_data", if_data, 32'h1004);
                check("t2_lsb_idle", {31'd0, lsb_done}, 32'd0);
            end else begin
                check("t2_lsb_addr", seen_addr, 32'h2000);
                check("t2_lsb_done", {31'd0, lsb_done}, 32'd1);
                check("t2_lsb_rdata", lsb_rdata, 32'h1000 + 32'(i));
                check("t2_if_idle", {31'd0, if_done}, 32'd0);
            end
        end
        last_if = 32'h1004;
        last_lsb = 32'h1005;
        if_req = 1'b0;
        lsb_req = 1'b0;
        step();

        // 3: IO-space store held off while the IO buffer is full
        io_buffer_full = 1'b1;
        lsb_req = 1'b1;
        lsb_wr = 1'b1;
        lsb_addr = 32'h0003_0000;
        lsb_size = 2'd0;
        lsb_wdata = 32'h55;
        if_req = 1'b1;
        if_addr = 32'h300;
        for (int i = 0; i < 2; i++) begin
            serve(32'h2000 + 32'(i), 2, seen_addr);
            check("t3_fetch_addr", seen_addr, 32'h300);
            check("t3_if_done", {31'd0, if_done}, 32'd1);
        end
        last_if = 32'h2001;
        if_req = 1'b0;
        io_buffer_full = 1'b0;
        step();
        check("t3_idle_gap", {31'd0, eng_valid}, 32'd0);
        step();
        check("t3_st_valid", {31'd0, eng_valid}, 32'd1);
        check("t3_st_addr", eng_addr, 32'h0003_0000);
        check("t3_st_wr", {31'd0, eng_wr}, 32'd1);
        check("t3_st_size", {30'd0, eng_size}, 32'd0);
        check("t3_st_wdata", eng_wdata, 32'h55);
        serve(last_lsb, 0, seen_addr);
        check("t3_st_done", {31'd0, lsb_done}, 32'd1);
        lsb_req = 1'b0;
        step();

        // 4: flush during a load in WAIT
        lsb_req = 1'b1;
        lsb_wr = 1'b0;
        lsb_addr = 32'h2004;
        lsb_size = 2'd1;
        wait_valid();
        eng_ready = 1'b1;
        step();
        eng_ready = 1'b0;
        rob_clear_up = 1'b1;
        lsb_req = 1'b0;
        step();
        rob_clear_up = 1'b0;
        step();
        eng_done = 1'b1;
        eng_rdata = 32'h1234;
        step();
        eng_done = 1'b0;
        check("t4_no_done", {31'd0, lsb_done}, 32'd0);
        check("t4_rdata_kept", lsb_rdata, last_lsb);
        step();
        check("t4_no_done_late", {31'd0, lsb_done}, 32'd0);
        lsb_req = 1'b1;
        lsb_addr = 32'h2008;
        lsb_size = 2'd2;
        serve(32'hBEEF, 1, seen_addr);
        check("t4_next_addr", seen_addr, 32'h2008);
        check("t4_next_done", {31'd0, lsb_done}, 32'd1);
        check("t4_next_rdata", lsb_rdata, 32'hBEEF);
        last_lsb = 32'hBEEF;
        lsb_req = 1'b0;
        step();

        // 5: flush during a stalled store in ISSUE
        lsb_req = 1'b1;
        lsb_wr = 1'b1;
        lsb_addr = 32'h1000;
        lsb_size = 2'd2;
        lsb_wdata = 32'hDEAD_BEEF;
        wait_valid();
        rob_clear_up = 1'b1;
        step();
        rob_clear_up = 1'b0;
        check("t5_hold_valid", {31'd0, eng_valid}, 32'd1);
        check("t5_hold_addr", eng_addr, 32'h1000);
        check("t5_hold_wdata", eng_wdata, 32'hDEAD_BEEF);
        step();
        check("t5_hold_valid2", {31'd0, eng_valid}, 32'd1);
        serve(last_lsb, 1, seen_addr);
        check("t5_st_done", {31'd0, lsb_done}, 32'd1);
        lsb_req = 1'b0;
        step();

        // Fetch flushed in the same cycle as eng_done
        if_req = 1'b1;
        if_addr = 32'h500;
        wait_valid();
        eng_ready = 1'b1;
        step();
        eng_ready = 1'b0;
        step();
        eng_done = 1'b1;
        eng_rdata = 32'hFFFF;
        rob_clear_up = 1'b1;
        if_req = 1'b0;
        step();
        eng_done = 1'b0;
        rob_clear_up = 1'b0;
        check("t5b_no_if_done", {31'd0, if_done}, 32'd0);
        check("t5b_if_data_kept", if_data, last_if);
        step();
        check("t5b_idle", {31'd0, eng_valid}, 32'd0);

        // 6: rdy_in low across a registered done
        lsb_req = 1'b1;
        lsb_wr = 1'b0;
        lsb_addr = 32'h2010;
        serve(32'h0BAD_F00D, 1, seen_addr);
        rdy_in = 1'b0;
        lsb_req = 1'b0;
        #1;
        check("t6_gated0", {31'd0, lsb_done}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("t6_gated", {31'd0, lsb_done}, 32'd0);
        end
        step();
        rdy_in = 1'b1;
        #1;
        check("t6_done", {31'd0, lsb_done}, 32'd1);
        check("t6_rdata", lsb_rdata, 32'h0BAD_F00D);
        step();
        check("t6_done_once", {31'd0, lsb_done}, 32'd0);

        // Reset asserted mid-WAIT
        if_req = 1'b1;
        if_addr = 32'h400;
        wait_valid();
        eng_ready = 1'b1;
        step();
        eng_ready = 1'b0;
        rst_in = 1'b1;
        #1;
        check("t6r_valid", {31'd0, eng_valid}, 32'd0);
        check("t6r_addr", eng_addr, 32'd0);
        check("t6r_if_data", if_data, 32'd0);
        check("t6r_lsb_rdata", lsb_rdata, 32'd0);
        check("t6r_dones", {30'd0, if_done, lsb_done}, 32'd0);
        if_req = 1'b0;
        step();
        rst_in = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
